canvas_streamer: RTL and testbench
==================================

// Module: canvas_streamer
// PURPOSE
//  Reader side of the 28x28 drawing canvas: on Start, walks every canvas cell in
//  MNIST row-major order and emits one pixel per beat on a valid/ready stream.
//  Sits between the canvas register array and the NN input-layer loader.
//  Asserts Busy so top level can hold canvas editing (Run) off while streaming.
// PARAMETERS
//  MAX_VAL     2047  saturation ceiling applied to each canvas cell before output
//  SCALE_SHIFT 0     right shift applied after clamping (0..11)
// PORTS
//  Clk          input   1          system clock; all state updates on rising edge
//  Reset        input   1          synchronous, active-high reset
//  Start        input   1          begin a stream; sampled only in IDLE
//  Abort        input   1          sync abort; return to IDLE, no Done pulse
//  canvas       input   16x28x28   canvas[x][y]; x = column 0..27, y = row 0..27
//  Pixel_Ready  input   1          downstream accepts beat when high with Pixel_Valid
//  Pixel_Valid  output  1          Pixel_Data/Pixel_Index/Last hold a valid beat
//  Pixel_Data   output  16         min(canvas[x][y], MAX_VAL) >> SCALE_SHIFT
//  Pixel_Index  output  10         y*28 + x, range 0..783
//  Last         output  1          high on the beat with Pixel_Index == 783
//  Busy         output  1          high in STREAM and DONE
//  Done         output  1          one-cycle pulse after the last beat is accepted
// BEHAVIOUR
//  - Reset: state IDLE; Pixel_Valid, Pixel_Data, Pixel_Index, Last, Busy, Done = 0;
//    internal x/y counters = 0. Reset mid-stream discards the stream; no Done.
//  - States: IDLE -> STREAM on Start; STREAM -> DONE when beat 783 accepted;
//    DONE -> IDLE unconditionally next cycle (Done=1 only in DONE); any state
//    -> IDLE on Abort (Abort has priority over Start and handshake).
//  - Latency: Start sampled high in IDLE -> next cycle Pixel_Valid=1, index 0,
//    Pixel_Data from canvas[0][0] as sampled on that Start edge.
//  - All outputs registered. Beat transfers on cycle where Pixel_Valid&&Pixel_Ready.
//  - On transfer of a non-last beat: next-cycle outputs carry the next pixel
//    (x+1; x wraps 27->0 with y+1); Pixel_Valid stays 1 -> 1 beat/cycle with Ready=1.
//  - Backpressure: while Pixel_Valid && !Pixel_Ready, Pixel_Data, Pixel_Index and
//    Last hold stable even if canvas changes; counters do not advance.
//  - Canvas sampled live at load time of each beat; consistency relies on Busy
//    gating edits upstream.
//  - Start while Busy ignored. Start and Reset same cycle: Reset wins.
//  - Arithmetic: clamp compare on full 16 bits, clamp to MAX_VAL, then logical
//    right shift; upper bits zero-filled.
//  - After last beat accepted: Pixel_Valid=0, Last=0 in DONE; Done=1 one cycle.
//  - Index never exceeds 783; no further beats until next Start.
// TESTING
//  1 Reset held 3 cycles, Start=1 during -> all outputs 0, state IDLE afterward.
//  2 canvas[x][y]=y*28+x, Ready=1, Start pulse -> 784 beats on consecutive
//    cycles, Data==Index each beat, Last only at 783, Done 1 cycle after it.
//  3 Boundary order: canvas[27][0]=111, canvas[0][1]=222, canvas[27][27]=333 ->
//    index 27 data 111, index 28 data 222, index 783 data 333 with Last=1.
//  4 Backpressure: Ready low 5 cycles while index 100 presented, canvas changed
//    meanwhile -> Data/Index held at original; index 101 follows release.
//  5 Clamp/shift: canvas[0][0]=4000 -> 2047 (SHIFT=0); SHIFT=3 build -> 255.
//  6 Abort at index 400 and Start mid-stream -> IDLE, no Done, Start ignored
//    while Busy; fresh Start afterward restarts at index 0.

Source files
------------

// File: rtl/canvas_streamer.sv
// canvas_streamer: walks the 28x28 canvas row-major and emits clamped/shifted pixels on a valid/ready stream
module canvas_streamer #(
    parameter int unsigned MAX_VAL     = 2047,
    parameter int unsigned SCALE_SHIFT = 0
) (
    input  logic                      Clk,
    input  logic                      Reset,
    input  logic                      Start,
    input  logic                      Abort,
    input  logic [27:0][27:0][15:0]   canvas,
    input  logic                      Pixel_Ready,
    output logic                      Pixel_Valid,
    output logic [15:0]               Pixel_Data,
    output logic [9:0]                Pixel_Index,
    output logic                      Last,
    output logic                      Busy,
    output logic                      Done
);
    typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;
    localparam logic [15:0] MAX_V = 16'(MAX_VAL);

    state_t      state_q, state_d;
    logic [4:0]  x_q, x_d, y_q, y_d, nx, ny;
    logic        valid_q, valid_d, last_q, last_d, busy_q, busy_d, done_q, done_d;
    logic [15:0] data_q, data_d, raw, clamped;
    logic [9:0]  index_q, index_d;

    always_comb begin
        // Coordinate of the pixel loaded on the next beat; IDLE always loads (0,0)
        nx      = (state_q == IDLE) ? 5'd0 : (x_q == 5'd27 ? 5'd0 : x_q + 5'd1);
        ny      = (state_q == IDLE) ? 5'd0 : (x_q == 5'd27 ? y_q + 5'd1 : y_q);
        raw     = canvas[nx][ny];
        clamped = (raw > MAX_V) ? MAX_V : raw;
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        valid_d = valid_q;
        data_d  = data_q;
        index_d = index_q;
        last_d  = last_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        if (Abort) begin
            state_d = IDLE;
            x_d     = '0;
            y_d     = '0;
            valid_d = 1'b0;
            data_d  = '0;
            index_d = '0;
            last_d  = 1'b0;
            busy_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: if (Start) begin
                    state_d = STREAM;
                    x_d     = '0;
                    y_d     = '0;
                    valid_d = 1'b1;
                    data_d  = clamped >> SCALE_SHIFT;
                    index_d = '0;
                    last_d  = 1'b0;
                    busy_d  = 1'b1;
                end
                STREAM: if (valid_q && Pixel_Ready) begin
                    if (last_q) begin
                        state_d = DONE;
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        x_d     = nx;
                        y_d     = ny;
                        data_d  = clamped >> SCALE_SHIFT;
                        index_d = index_q + 10'd1;
                        last_d  = (index_q == 10'd782);
                    end
                end
                DONE: begin
                    state_d = IDLE;
                    x_d     = '0;
                    y_d     = '0;
                    busy_d  = 1'b0;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            index_q <= '0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            index_q <= index_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign Pixel_Valid = valid_q;
    assign Pixel_Data  = data_q;
    assign Pixel_Index = index_q;
    assign Last        = last_q;
    assign Busy        = busy_q;
    assign Done        = done_q;
endmodule

// File: tb/tb_canvas_streamer.sv
// tb_canvas_streamer: directed checks of canvas_streamer, with a SCALE_SHIFT=3 instance sharing the inputs
module tb_canvas_streamer;
    logic                    Clk = 1'b0;
    logic                    Reset = 1'b1, Start = 1'b0, Abort = 1'b0, Pixel_Ready = 1'b0;
    logic [27:0][27:0][15:0] canvas = '0;
    logic                    Pixel_Valid, Last, Busy, Done;
    logic [15:0]             Pixel_Data;
    logic [9:0]              Pixel_Index;
    logic                    d3_valid, d3_last, d3_busy, d3_done;
    logic [15:0]             d3_data;
    logic [9:0]              d3_index;
    int checks = 0, failures = 0;

    canvas_streamer dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Abort(Abort), .canvas(canvas),
        .Pixel_Ready(Pixel_Ready), .Pixel_Valid(Pixel_Valid), .Pixel_Data(Pixel_Data),
        .Pixel_Index(Pixel_Index), .Last(Last), .Busy(Busy), .Done(Done)
    );

    canvas_streamer #(.SCALE_SHIFT(3)) dut3 (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Abort(Abort), .canvas(canvas),
        .Pixel_Ready(Pixel_Ready), .Pixel_Valid(d3_valid), .Pixel_Data(d3_data),
        .Pixel_Index(d3_index), .Last(d3_last), .Busy(d3_busy), .Done(d3_done)
    );

    always #5 Clk = ~Clk;

    task automatic fill_identity();
        for (int x = 0; x < 28; x++)
            for (int y = 0; y < 28; y++)
                canvas[x][y] = 16'(y * 28 + x);
    endtask

    task automatic start_pulse();
        Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        Start = 1'b1;
        repeat (3) @(negedge Clk);
        checks++;
        if ({Pixel_Valid, Pixel_Data, Pixel_Index, Last, Busy, Done} !== 30'd0) begin
            failures++;
            $display("FAIL reset_hold: valid=%b data=%0d idx=%0d last=%b busy=%b done=%b, want all 0",
                     Pixel_Valid, Pixel_Data, Pixel_Index, Last, Busy, Done);
        end
        Reset = 1'b0;
        Start = 1'b0;
        repeat (2) @(negedge Clk);
        checks++;
        if ({Pixel_Valid, Busy, Done} !== 3'b000) begin
            failures++;
            $display("FAIL reset_idle: valid=%b busy=%b done=%b, want 0 0 0", Pixel_Valid, Busy, Done);
        end
    endtask

    task automatic test_stream();
        fill_identity();
        Pixel_Ready = 1'b1;
        start_pulse();
        for (int k = 0; k < 784; k++) begin
            checks++;
            if (Pixel_Valid !== 1'b1 || Pixel_Index !== 10'(k) || Pixel_Data !== 16'(k) ||
                Last !== (k == 783) || Busy !== 1'b1 || Done !== 1'b0) begin
                failures++;
                $display("FAIL stream_beat %0d: valid=%b idx=%0d data=%0d last=%b busy=%b done=%b, want 1 %0d %0d %b 1 0",
                         k, Pixel_Valid, Pixel_Index, Pixel_Data, Last, Busy, Done, k, k, k == 783);
            end
            checks++;
            if (d3_data !== 16'(k >> 3) || d3_index !== 10'(k)) begin
                failures++;
                $display("FAIL stream_shift3 %0d: data=%0d idx=%0d, want %0d %0d", k, d3_data, d3_index, k >> 3, k);
            end
            @(negedge Clk);
        end
        checks++;
        if ({Pixel_Valid, Last, Busy, Done} !== 4'b0011) begin
            failures++;
            $display("FAIL stream_done: valid=%b last=%b busy=%b done=%b, want 0 0 1 1", Pixel_Valid, Last, Busy, Done);
        end
        @(negedge Clk);
        checks++;
        if ({Pixel_Valid, Busy, Done} !== 3'b000) begin
            failures++;
            $display("FAIL stream_after_done: valid=%b busy=%b done=%b, want 0 0 0", Pixel_Valid, Busy, Done);
        end
    endtask

    task automatic test_boundary();
        logic [15:0] exp;
        canvas = '0;
        canvas[27][0]  = 16'd111;
        canvas[0][1]   = 16'd222;
        canvas[27][27] = 16'd333;
        Pixel_Ready = 1'b1;
        start_pulse();
        for (int k = 0; k < 784; k++) begin
            exp = (k == 27) ? 16'd111 : (k == 28) ? 16'd222 : (k == 783) ? 16'd333 : 16'd0;
            checks++;
            if (Pixel_Index !== 10'(k) || Pixel_Data !== exp || Last !== (k == 783)) begin
                failures++;
                $display("FAIL boundary_beat %0d: idx=%0d data=%0d last=%b, want %0d %0d %b",
                         k, Pixel_Index, Pixel_Data, Last, k, exp, k == 783);
            end
            @(negedge Clk);
        end
        checks++;
        if (Done !== 1'b1) begin
            failures++;
            $display("FAIL boundary_done: done=%b, want 1", Done);
        end
        @(negedge Clk);
    endtask

    task automatic test_backpressure();
        fill_identity();
        Pixel_Ready = 1'b1;
        start_pulse();
        repeat (100) @(negedge Clk);
        checks++;
        if (Pixel_Index !== 10'd100 || Pixel_Data !== 16'd100) begin
            failures++;
            $display("FAIL bp_reach: idx=%0d data=%0d, want 100 100", Pixel_Index, Pixel_Data);
        end
        Pixel_Ready = 1'b0;
        canvas[16][3] = 16'hBEEF;
        canvas[17][3] = 16'd777;
        for (int c = 0; c < 5; c++) begin
            @(negedge Clk);
            canvas[0][0] = 16'(c + 9);
            checks++;
            if (Pixel_Valid !== 1'b1 || Pixel_Index !== 10'd100 || Pixel_Data !== 16'd100 || Last !== 1'b0) begin
                failures++;
                $display("FAIL bp_hold cycle %0d: valid=%b idx=%0d data=%0d last=%b, want 1 100 100 0",
                         c, Pixel_Valid, Pixel_Index, Pixel_Data, Last);
            end
        end
        Pixel_Ready = 1'b1;
        @(negedge Clk);
        checks++;
        if (Pixel_Valid !== 1'b1 || Pixel_Index !== 10'd101 || Pixel_Data !== 16'd777) begin
            failures++;
            $display("FAIL bp_release: valid=%b idx=%0d data=%0d, want 1 101 777", Pixel_Valid, Pixel_Index, Pixel_Data);
        end
        Abort = 1'b1;
        @(negedge Clk);
        Abort = 1'b0;
        checks++;
        if ({Pixel_Valid, Busy, Done} !== 3'b000) begin
            failures++;
            $display("FAIL bp_abort: valid=%b busy=%b done=%b, want 0 0 0", Pixel_Valid, Busy, Done);
        end
    endtask

    task automatic test_clamp_shift();
        logic [15:0] in_v [5] = '{16'd4000, 16'd2047, 16'd2048, 16'hFFFF, 16'd7};
        logic [15:0] exp0 [5] = '{16'd2047, 16'd2047, 16'd2047, 16'd2047, 16'd7};
        logic [15:0] exp3 [5] = '{16'd255, 16'd255, 16'd255, 16'd255, 16'd0};
        canvas = '0;
        for (int k = 0; k < 5; k++) canvas[k][0] = in_v[k];
        Pixel_Ready = 1'b1;
        start_pulse();
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (Pixel_Index !== 10'(k) || Pixel_Data !== exp0[k] || d3_data !== exp3[k]) begin
                failures++;
                $display("FAIL clamp_shift in=%0d: idx=%0d data=%0d data_s3=%0d, want %0d %0d %0d",
                         in_v[k], Pixel_Index, Pixel_Data, d3_data, k, exp0[k], exp3[k]);
            end
            @(negedge Clk);
        end
        Abort = 1'b1;
        @(negedge Clk);
        Abort = 1'b0;
    endtask

    task automatic test_abort_restart();
        fill_identity();
        Pixel_Ready = 1'b1;
        start_pulse();
        for (int k = 0; k <= 400; k++) begin
            Start = (k == 200);
            checks++;
            if (Pixel_Valid !== 1'b1 || Pixel_Index !== 10'(k) || Pixel_Data !== 16'(k)) begin
                failures++;
                $display("FAIL abort_run beat %0d: valid=%b idx=%0d data=%0d, want 1 %0d %0d",
                         k, Pixel_Valid, Pixel_Index, Pixel_Data, k, k);
            end
            if (k < 400) @(negedge Clk);
        end
        Start = 1'b0;
        Abort = 1'b1;
        @(negedge Clk);
        Abort = 1'b0;
        checks++;
        if ({Pixel_Valid, Busy, Done} !== 3'b000 || Pixel_Index !== 10'd0) begin
            failures++;
            $display("FAIL abort_idle: valid=%b busy=%b done=%b idx=%0d, want 0 0 0 0", Pixel_Valid, Busy, Done, Pixel_Index);
        end
        @(negedge Clk);
        checks++;
        if ({Pixel_Valid, Done} !== 2'b00) begin
            failures++;
            $display("FAIL abort_no_done: valid=%b done=%b, want 0 0", Pixel_Valid, Done);
        end
        start_pulse();
        checks++;
        if (Pixel_Valid !== 1'b1 || Pixel_Index !== 10'd0 || Pixel_Data !== 16'd0 || Busy !== 1'b1) begin
            failures++;
            $display("FAIL restart: valid=%b idx=%0d data=%0d busy=%b, want 1 0 0 1", Pixel_Valid, Pixel_Index, Pixel_Data, Busy);
        end
        Start = 1'b1;
        Abort = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        Abort = 1'b0;
        checks++;
        if ({Pixel_Valid, Busy, Done} !== 3'b000) begin
            failures++;
            $display("FAIL abort_over_start: valid=%b busy=%b done=%b, want 0 0 0", Pixel_Valid, Busy, Done);
        end
    endtask

    initial begin
        @(negedge Clk);
        test_reset();
        test_stream();
        test_boundary();
        test_backpressure();
        test_clamp_shift();
        test_abort_restart();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
